// File: rtl/sys_defs.sv
// ============================================================================
// Module : sys_defs (package)
// Desc   : Shared widths and the write-back buffer entry type for regfile.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

package sys_defs;

  localparam int REG_NUM    = 32;
  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = `DATA_WIDTH;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] addr;
    logic [DATA_W-1:0]     data;
  } wb_entry_t;

endpackage

`default_nettype wire

// File: rtl/regfile_fwd.sv
// ============================================================================
// Module : regfile_fwd
// Desc   : Per-port read mux: incoming write > write-back buffer > array.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_fwd
  import sys_defs::*;
#(
  parameter bit BYPASS_EN = 1'b0
) (
  input  logic                  clr_i,
  input  logic                  ena_i,
  input  logic [REG_ADDR_W-1:0] addr_i,
  input  logic                  wr_ena_i,
  input  logic [REG_ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0]     wr_data_i,
  input  wb_entry_t             wb_i,
  input  logic [DATA_W-1:0]     arr_data_i,
  output logic [DATA_W-1:0]     data_o
);

  logic w_byp_hit;
  logic w_buf_hit;

  assign w_byp_hit = BYPASS_EN && wr_ena_i && (wr_addr_i == addr_i);
  assign w_buf_hit = wb_i.valid && (wb_i.addr == addr_i);

  // x0 and disabled ports read zero, as does every port while in reset.
  always_comb begin
    data_o = '0;
    if (!clr_i && ena_i && (addr_i != '0)) begin
      if (w_byp_hit) begin
        data_o = wr_data_i;
      end else if (w_buf_hit) begin
        data_o = wb_i.data;
      end else begin
        data_o = arr_data_i;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/regfile.sv
// ============================================================================
// Module : regfile
// Desc   : 32-entry register file with a one-entry write-back buffer and
//          forwarding; REGFILE_BYPASS_EN adds a same-cycle write-to-read path.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile
  import sys_defs::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rs1_r_ena,
  input  logic [REG_ADDR_W-1:0] rs1_r_addr,
  input  logic                  rs2_r_ena,
  input  logic [REG_ADDR_W-1:0] rs2_r_addr,
  input  logic                  rd_w_ena,
  input  logic [REG_ADDR_W-1:0] rd_w_addr,
  input  logic [DATA_W-1:0]     rd_data,
  input  logic [REG_ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0]     rs1_data,
  output logic [DATA_W-1:0]     rs2_data,
  output logic [DATA_W-1:0]     dbg_data,
  output logic                  wb_pending
);

`ifdef REGFILE_BYPASS_EN
  localparam bit C_BYPASS_EN = 1'b1;
`else
  localparam bit C_BYPASS_EN = 1'b0;
`endif

  logic [DATA_W-1:0] mem_q [REG_NUM];
  wb_entry_t         wb_q;
  wb_entry_t         wb_d;
  logic              w_wr_acc;

  // Writes to x0 never enter the buffer.
  assign w_wr_acc = rd_w_ena && (rd_w_addr != '0);

  always_comb begin
    wb_d       = wb_q;
    wb_d.valid = 1'b0;
    if (w_wr_acc) begin
      wb_d.valid = 1'b1;
      wb_d.addr  = rd_w_addr;
      wb_d.data  = rd_data;
    end
  end

  // Old buffer entry commits on the same edge a new write reloads it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_q <= '0;
      for (int i = 0; i < REG_NUM; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wb_q <= wb_d;
      if (wb_q.valid) begin
        mem_q[wb_q.addr] <= wb_q.data;
      end
    end
  end

  assign wb_pending = wb_q.valid;

  regfile_fwd #(.BYPASS_EN(C_BYPASS_EN)) u_fwd_rs1 (
    .clr_i      (rst),
    .ena_i      (rs1_r_ena),
    .addr_i     (rs1_r_addr),
    .wr_ena_i   (rd_w_ena),
    .wr_addr_i  (rd_w_addr),
    .wr_data_i  (rd_data),
    .wb_i       (wb_q),
    .arr_data_i (mem_q[rs1_r_addr]),
    .data_o     (rs1_data)
  );

  regfile_fwd #(.BYPASS_EN(C_BYPASS_EN)) u_fwd_rs2 (
    .clr_i      (rst),
    .ena_i      (rs2_r_ena),
    .addr_i     (rs2_r_addr),
    .wr_ena_i   (rd_w_ena),
    .wr_addr_i  (rd_w_addr),
    .wr_data_i  (rd_data),
    .wb_i       (wb_q),
    .arr_data_i (mem_q[rs2_r_addr]),
    .data_o     (rs2_data)
  );

  regfile_fwd #(.BYPASS_EN(1'b0)) u_fwd_dbg (
    .clr_i      (rst),
    .ena_i      (1'b1),
    .addr_i     (dbg_addr),
    .wr_ena_i   (rd_w_ena),
    .wr_addr_i  (rd_w_addr),
    .wr_data_i  (rd_data),
    .wb_i       (wb_q),
    .arr_data_i (mem_q[dbg_addr]),
    .data_o     (dbg_data)
  );

endmodule

`default_nettype wire

// File: tb/tb_regfile.sv
// ============================================================================
// Module : tb_regfile
// Desc   : Directed self-checking bench for regfile (either bypass build).
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_regfile;
  import sys_defs::*;

`ifdef REGFILE_BYPASS_EN
  localparam bit C_BYP = 1'b1;
`else
  localparam bit C_BYP = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              rs1_r_ena;
  logic [4:0]        rs1_r_addr;
  logic              rs2_r_ena;
  logic [4:0]        rs2_r_addr;
  logic              rd_w_ena;
  logic [4:0]        rd_w_addr;
  logic [DATA_W-1:0] rd_data;
  logic [4:0]        dbg_addr;
  logic [DATA_W-1:0] rs1_data;
  logic [DATA_W-1:0] rs2_data;
  logic [DATA_W-1:0] dbg_data;
  logic              wb_pending;

  int vectors     = 0;
  int miscompares = 0;

  regfile dut (
    .clk        (clk),
    .rst        (rst),
    .rs1_r_ena  (rs1_r_ena),
    .rs1_r_addr (rs1_r_addr),
    .rs2_r_ena  (rs2_r_ena),
    .rs2_r_addr (rs2_r_addr),
    .rd_w_ena   (rd_w_ena),
    .rd_w_addr  (rd_w_addr),
    .rd_data    (rd_data),
    .dbg_addr   (dbg_addr),
    .rs1_data   (rs1_data),
    .rs2_data   (rs2_data),
    .dbg_data   (dbg_data),
    .wb_pending (wb_pending)
  );

  always #5 clk = ~clk;

  task automatic set_wr(input logic en, input logic [4:0] a, input logic [DATA_W-1:0] d);
    rd_w_ena  = en;
    rd_w_addr = a;
    rd_data   = d;
  endtask

  task automatic set_rd(input logic e1, input logic [4:0] a1,
                        input logic e2, input logic [4:0] a2, input logic [4:0] ad);
    rs1_r_ena  = e1;
    rs1_r_addr = a1;
    rs2_r_ena  = e2;
    rs2_r_addr = a2;
    dbg_addr   = ad;
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 ns later.
  task automatic next_cycle();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_wr(1'b0, 5'd0, '0);
    set_rd(1'b1, 5'd5, 1'b1, 5'd31, 5'd1);
    repeat (2) @(posedge clk);
    next_cycle();
    #1;
    vectors++;
    if (rs1_data !== '0 || rs2_data !== '0 || dbg_data !== '0) begin
      miscompares++;
      $display("FAIL reset_rd: rs1=%h rs2=%h dbg=%h expected all 0", rs1_data, rs2_data, dbg_data);
    end
    vectors++;
    if (wb_pending !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_pend: got %b expected 0", wb_pending);
    end
    rst = 1'b0;
  endtask

  task automatic test_write_read();
    next_cycle();
    set_wr(1'b1, 5'd5, 'h1234);
    set_rd(1'b1, 5'd5, 1'b0, 5'd0, 5'd5);
    #1;
    vectors++;
    if (rs1_data !== (C_BYP ? DATA_W'('h1234) : DATA_W'(0))) begin
      miscompares++;
      $display("FAIL wr_same_cycle: rs1 got %h expected %h", rs1_data, C_BYP ? 'h1234 : 0);
    end
    next_cycle();
    set_wr(1'b0, 5'd0, '0);
    #1;
    vectors++;
    if (rs1_data !== DATA_W'('h1234) || wb_pending !== 1'b1) begin
      miscompares++;
      $display("FAIL wr_n1: rs1=%h pend=%b expected 1234/1", rs1_data, wb_pending);
    end
    next_cycle();
    #1;
    vectors++;
    if (rs1_data !== DATA_W'('h1234) || wb_pending !== 1'b0) begin
      miscompares++;
      $display("FAIL wr_n2: rs1=%h pend=%b expected 1234/0", rs1_data, wb_pending);
    end
  endtask

  task automatic test_x0();
    next_cycle();
    set_wr(1'b1, 5'd0, 'hFFFF);
    set_rd(1'b1, 5'd0, 1'b1, 5'd0, 5'd0);
    next_cycle();
    set_wr(1'b0, 5'd0, '0);
    #1;
    vectors++;
    if (rs1_data !== '0 || rs2_data !== '0 || dbg_data !== '0) begin
      miscompares++;
      $display("FAIL x0_read: rs1=%h rs2=%h dbg=%h expected 0", rs1_data, rs2_data, dbg_data);
    end
    vectors++;
    if (wb_pending !== 1'b0) begin
      miscompares++;
      $display("FAIL x0_pend: got %b expected 0", wb_pending);
    end
  endtask

  task automatic test_disable();
    next_cycle();
    set_rd(1'b0, 5'd5, 1'b0, 5'd5, 5'd5);
    #1;
    vectors++;
    if (rs1_data !== '0 || rs2_data !== '0) begin
      miscompares++;
      $display("FAIL rd_disable: rs1=%h rs2=%h expected 0", rs1_data, rs2_data);
    end
    vectors++;
    if (dbg_data !== DATA_W'('h1234)) begin
      miscompares++;
      $display("FAIL dbg_x5: got %h expected 1234", dbg_data);
    end
  endtask

  task automatic test_bypass();
    next_cycle();
    set_wr(1'b1, 5'd7, 'h11);
    next_cycle();
    set_wr(1'b0, 5'd0, '0);
    next_cycle();
    set_wr(1'b1, 5'd7, 'hAA);
    set_rd(1'b1, 5'd5, 1'b1, 5'd7, 5'd7);
    #1;
    vectors++;
    if (rs2_data !== (C_BYP ? DATA_W'('hAA) : DATA_W'('h11))) begin
      miscompares++;
      $display("FAIL byp_rs2: got %h expected %h", rs2_data, C_BYP ? 'hAA : 'h11);
    end
    vectors++;
    if (dbg_data !== DATA_W'('h11)) begin
      miscompares++;
      $display("FAIL byp_dbg: got %h expected 11", dbg_data);
    end
    next_cycle();
    set_wr(1'b0, 5'd0, '0);
    #1;
    vectors++;
    if (rs2_data !== DATA_W'('hAA) || dbg_data !== DATA_W'('hAA)) begin
      miscompares++;
      $display("FAIL byp_next: rs2=%h dbg=%h expected aa/aa", rs2_data, dbg_data);
    end
  endtask

  task automatic test_back_to_back();
    logic [DATA_W-1:0] exp1 [5];
    logic [DATA_W-1:0] exp2 [5];
    logic              expp [5];
    exp1 = '{C_BYP ? 1 : 0, C_BYP ? 2 : 1, 2, 2, 2};
    exp2 = '{0, 0, C_BYP ? 3 : 0, 3, 3};
    expp = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    for (int c = 0; c < 5; c++) begin
      next_cycle();
      case (c)
        0: set_wr(1'b1, 5'd3, 'd1);
        1: set_wr(1'b1, 5'd3, 'd2);
        2: set_wr(1'b1, 5'd4, 'd3);
        default: set_wr(1'b0, 5'd0, '0);
      endcase
      set_rd(1'b1, 5'd3, 1'b1, 5'd4, 5'd3);
      #1;
      vectors++;
      if (rs1_data !== exp1[c] || rs2_data !== exp2[c] || wb_pending !== expp[c]) begin
        miscompares++;
        $display("FAIL b2b_c%0d: rs1=%h rs2=%h pend=%b expected %h %h %b",
                 c, rs1_data, rs2_data, wb_pending, exp1[c], exp2[c], expp[c]);
      end
    end
  endtask

  task automatic test_async_reset();
    next_cycle();
    set_wr(1'b1, 5'd9, 'h55);
    set_rd(1'b1, 5'd5, 1'b1, 5'd3, 5'd9);
    next_cycle();
    set_wr(1'b0, 5'd0, '0);
    #1;
    vectors++;
    if (dbg_data !== DATA_W'('h55) || wb_pending !== 1'b1) begin
      miscompares++;
      $display("FAIL ar_pre: dbg=%h pend=%b expected 55/1", dbg_data, wb_pending);
    end
    #1;
    rst = 1'b1;
    #1;
    vectors++;
    if (dbg_data !== '0 || wb_pending !== 1'b0) begin
      miscompares++;
      $display("FAIL ar_immediate: dbg=%h pend=%b expected 0/0", dbg_data, wb_pending);
    end
    vectors++;
    if (rs1_data !== '0 || rs2_data !== '0) begin
      miscompares++;
      $display("FAIL ar_rd: rs1=%h rs2=%h expected 0", rs1_data, rs2_data);
    end
    next_cycle();
    rst = 1'b0;
    next_cycle();
    next_cycle();
    #1;
    vectors++;
    if (dbg_data !== '0 || wb_pending !== 1'b0) begin
      miscompares++;
      $display("FAIL ar_after: dbg=%h pend=%b expected 0/0", dbg_data, wb_pending);
    end
    set_wr(1'b1, 5'd9, 'h66);
    next_cycle();
    set_wr(1'b0, 5'd0, '0);
    #1;
    vectors++;
    if (dbg_data !== DATA_W'('h66) || wb_pending !== 1'b1) begin
      miscompares++;
      $display("FAIL ar_first_wr: dbg=%h pend=%b expected 66/1", dbg_data, wb_pending);
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_x0();
    test_disable();
    test_bypass();
    test_back_to_back();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/regfile.md
REGFILE -- requirements
Module: regfile

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 rst  input  1  asynchronous, active-high reset.
REQ-003 rs1_r_ena  input  1  read enable, port 1.
REQ-004 rs1_r_addr  input  5  register index, port 1.
REQ-005 rs2_r_ena  input  1  read enable, port 2.
REQ-006 rs2_r_addr  input  5  register index, port 2.
REQ-007 rd_w_ena  input  1  write-back request.
REQ-008 rd_w_addr  input  5  write-back register index.
REQ-009 rd_data  input  `DATA_WIDTH  write-back value.
REQ-010 dbg_addr  input  5  debug read index; never bypassed from the incoming write port.
REQ-011 rs1_data  output  `DATA_WIDTH  read data, port 1, combinational.
REQ-012 rs2_data  output  `DATA_WIDTH  read data, port 2, combinational.
REQ-013 dbg_data  output  `DATA_WIDTH  debug read data, combinational.
REQ-014 wb_pending  output  1  a write is held in the write-back buffer.

Function
REQ-015 Storage SHALL be 32 x `DATA_WIDTH; x0 reads 0 on every port, and writes to x0 SHALL be dropped (no buffer entry, wb_pending unaffected).
REQ-016 A write accepted at edge N (rd_w_ena=1, rd_w_addr!=0) SHALL load the one-entry buffer (wb_valid, wb_addr, wb_data); the buffer SHALL commit to the array at edge N+1.
REQ-017 With no new write at an edge, a valid buffer SHALL commit and wb_valid SHALL clear; with a new write, the buffer SHALL commit its old entry and reload in the same edge (no stall, no loss).
REQ-018 Back-to-back writes to the same index SHALL leave the younger value in the array.
REQ-019 Read port with ena=0 SHALL output 0, regardless of address.
REQ-020 Read priority with ena=1, addr!=0: incoming write (only per REQ-027) > buffer hit (wb_valid & wb_addr==addr) > array.
REQ-021 Buffer forwarding SHALL always be active on rs1, rs2 and dbg; a write is visible to reads from the cycle after it is presented.
REQ-022 Both read ports SHALL operate independently and may read the same index in the same cycle.
REQ-023 wb_pending SHALL equal wb_valid.

Reset
REQ-024 While rst=1, all 32 registers SHALL be 0, wb_valid=0, wb_addr=0, wb_data=0; rst SHALL take effect immediately, without waiting for clk.
REQ-025 Reset asserted with a buffered write SHALL discard that write; the first write after release SHALL be accepted on the first clk edge with rst=0.
REQ-026 During reset, rs1_data, rs2_data and dbg_data SHALL be 0.

Configuration
REQ-027 Macro REGFILE_BYPASS_EN defined: rs1/rs2 SHALL return rd_data in the same cycle when rd_w_ena=1 and rd_w_addr matches a nonzero read address (write-to-read latency 0). Undefined: no same-cycle path, and latency is 1 cycle via the buffer.

Structure
REQ-028 sys_defs package SHALL hold `DATA_WIDTH, REG_NUM=32, REG_ADDR_W=5 and a typedef wb_entry_t {valid, addr, data}.
REQ-029 Sub-module regfile_fwd SHALL implement the per-port priority mux of REQ-020; it SHALL be instantiated three times (rs1, rs2, dbg), and the dbg instance SHALL have its incoming-write bypass disabled.

Verification
REQ-030 Write x5=0x1234 at edge N, read rs1 x5 in cycle N+1 -> 0x1234 with wb_pending=1; in cycle N+2 -> 0x1234 with wb_pending=0.
REQ-031 Write x0=0xFFFF, then read x0 on rs1 and rs2 -> 0; wb_pending stays 0.
REQ-032 Present write x7=0xAA and read rs2 x7 in the same cycle, with x7 holding 0x11 -> 0xAA if REGFILE_BYPASS_EN is defined, else 0x11; dbg x7 -> 0x11 in both builds.
REQ-033 Consecutive writes x3=1, x3=2, x4=3 on three edges, then idle -> x3=2, x4=3; every intermediate read matches REQ-020.
REQ-034 Buffer x9=0x55, then assert rst asynchronously between edges -> dbg x9=0 and wb_pending=0 immediately; after release, x9 stays 0.
REQ-035 rs1_r_ena=0 with addr=x5 holding 0x1234 -> rs1_data=0.
